// File: rtl/alu_share_pkg.sv
// Shared constants and state encoding for the ALU-sharing arbiter.
package alu_share_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester favoured on a tie
// and moves to the other requester whenever a grant is issued.
module rr_arb2
    import alu_share_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_valid_o,
    output logic       gnt_o
);

    logic ptr_q, ptr_d;

    // Grant selection and pointer update
    always_comb begin
        gnt_valid_o = en_i & (req_i[0] | req_i[1]);
        if (req_i[0] & req_i[1]) begin
            gnt_o = ptr_q;
        end else begin
            gnt_o = req_i[1];
        end
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = ~gnt_o;
        end
    end

    // Pointer register, requester 0 favoured out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrate, register
// operands into the ALU, capture the result a cycle later, hold it for the owner.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_addsub,
    output logic              alu_shift,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
);

    state_e state_q, state_d;
    logic owner_q, owner_d;
    logic err_q, err_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic alu_addsub_q, alu_addsub_d, alu_shift_q, alu_shift_d;
    logic rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
    logic rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;

    logic gnt_valid, gnt;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       ({req1_valid, req0_valid}),
        .en_i        (state_q == IDLE),
        .gnt_valid_o (gnt_valid),
        .gnt_o       (gnt)
    );

    assign sel_op = gnt ? req1_op : req0_op;
    assign sel_a  = gnt ? req1_a  : req0_a;
    assign sel_b  = gnt ? req1_b  : req0_b;

    // FSM next state, accept/decode and response capture
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        err_d        = err_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_addsub_d = alu_addsub_q;
        alu_shift_d  = alu_shift_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        rsp1_err_d   = rsp1_err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    req0_ready = ~gnt;
                    req1_ready = gnt;
                    owner_d    = gnt;
                    err_d      = (sel_op == OP_W'(OP_RSV));
                    // Reserved ops leave the ALU input registers untouched
                    if (sel_op != OP_W'(OP_RSV)) begin
                        alu_a_d      = sel_a;
                        alu_b_d      = sel_b;
                        alu_addsub_d = (sel_op != OP_W'(OP_SUB));
                        alu_shift_d  = (sel_op == OP_W'(OP_SHL));
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (owner_q) begin
                    rsp1_data_d  = err_q ? '0 : alu_out;
                    rsp1_err_d   = err_q;
                    rsp1_valid_d = 1'b1;
                end else begin
                    rsp0_data_d  = err_q ? '0 : alu_out;
                    rsp0_err_d   = err_q;
                    rsp0_valid_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ownership, ALU input and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_addsub_q <= 1'b0;
            alu_shift_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_err_q   <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            err_q        <= err_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_addsub_q <= alu_addsub_d;
            alu_shift_q  <= alu_shift_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_addsub = alu_addsub_q;
    assign alu_shift  = alu_shift_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_err   = rsp1_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter with a behavioural stand-in for ALU_n8.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_addsub, alu_shift, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(8), .OP_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_addsub(alu_addsub), .alu_shift(alu_shift),
        .alu_out(alu_out), .busy(busy)
    );

    // ALU stand-in: shift wins, otherwise add/sub
    assign alu_out = alu_shift ? {alu_a[6:0], 1'b0} : (alu_addsub ? alu_a + alu_b : alu_a - alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a << 1;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic rdy(input int id);
        return (id != 0) ? req1_ready : req0_ready;
    endfunction
    function automatic logic rspv(input int id);
        return (id != 0) ? rsp1_valid : rsp0_valid;
    endfunction
    function automatic logic [7:0] rspd(input int id);
        return (id != 0) ? rsp1_data : rsp0_data;
    endfunction
    function automatic logic rspe(input int id);
        return (id != 0) ? rsp1_err : rsp0_err;
    endfunction

    task automatic set_req(input int id, input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Scoreboard: expectation pushed on accept, popped on response handshake
    typedef struct {
        int         owner;
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t sbq[$];

    task automatic sb_pop(input int id, input logic [7:0] d, input logic e);
        exp_t x;
        if (sbq.size() == 0) begin
            chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
            x = sbq.pop_front();
            chk("sb_owner", id, x.owner);
            chk("sb_data", d, x.data);
            chk("sb_err", e, x.err);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (req0_valid && req0_ready)
                sbq.push_back('{0, model(req0_op, req0_a, req0_b), (req0_op == 2'b11)});
            if (req1_valid && req1_ready)
                sbq.push_back('{1, model(req1_op, req1_a, req1_b), (req1_op == 2'b11)});
            if (rsp0_valid || rsp1_valid)
                chk("single_owner_rsp", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp0_valid && rsp0_ready) sb_pop(0, rsp0_data, rsp0_err);
            if (rsp1_valid && rsp1_ready) sb_pop(1, rsp1_data, rsp1_err);
        end
    end

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] a, b;
        logic [7:0] ea, eb;
        logic       eas, esh;
        logic [7:0] ed;
        logic       ee;
    } vec_t;
    vec_t tbl[8];

    // One lone op from idle: ready at T, ALU inputs at T+1, response at T+2
    task automatic run_op(input int idx, input vec_t v);
        int n;
        set_req(v.id, 1'b1, v.op, v.a, v.b);
        @(negedge clk);
        n = 0;
        while (!rdy(v.id) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_ready", idx), rdy(v.id), 1);
        if (!rdy(v.id)) begin
            set_req(v.id, 1'b0, 2'b00, 8'h00, 8'h00);
            return;
        end
        @(posedge clk); #1;
        set_req(v.id, 1'b0, 2'b00, 8'h00, 8'h00);
        @(negedge clk);
        chk($sformatf("v%0d_alu_a", idx), alu_a, v.ea);
        chk($sformatf("v%0d_alu_b", idx), alu_b, v.eb);
        chk($sformatf("v%0d_alu_addsub", idx), alu_addsub, v.eas);
        chk($sformatf("v%0d_alu_shift", idx), alu_shift, v.esh);
        chk($sformatf("v%0d_busy_exec", idx), busy, 1);
        chk($sformatf("v%0d_rspv_exec", idx), rspv(v.id), 0);
        @(negedge clk);
        chk($sformatf("v%0d_rspv", idx), rspv(v.id), 1);
        chk($sformatf("v%0d_data", idx), rspd(v.id), v.ed);
        chk($sformatf("v%0d_err", idx), rspe(v.id), v.ee);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d_rspv_after", idx), rspv(v.id), 0);
        chk($sformatf("v%0d_busy_after", idx), busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 2'b01, 8'h10, 8'h20, 8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 1'b0};
        tbl[1] = '{0, 2'b00, 8'h12, 8'h05, 8'h12, 8'h05, 1'b1, 1'b0, 8'h17, 1'b0};
        tbl[2] = '{1, 2'b10, 8'h41, 8'h99, 8'h41, 8'h99, 1'b1, 1'b1, 8'h82, 1'b0};
        tbl[3] = '{0, 2'b00, 8'hFF, 8'h01, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1, 2'b01, 8'h33, 8'h11, 8'h33, 8'h11, 1'b0, 1'b0, 8'h22, 1'b0};
        tbl[5] = '{0, 2'b11, 8'hFF, 8'h77, 8'h33, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{1, 2'b10, 8'h80, 8'h00, 8'h80, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[7] = '{1, 2'b11, 8'hAA, 8'h55, 8'h80, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b0;
        set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
        set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_ctl", {alu_addsub, alu_shift}, 0);
        chk("rst_rsp0", {rsp0_valid, rsp0_err, rsp0_data}, 0);
        chk("rst_rsp1", {rsp1_valid, rsp1_err, rsp1_data}, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of lone ops, first one from requester 1 straight after reset
        for (int i = 0; i < 8; i++) run_op(i, tbl[i]);

        // Requester 0 op, reset pulsed during EXEC
        set_req(0, 1'b1, 2'b00, 8'h05, 8'h06);
        @(negedge clk);
        chk("pre_rst_ready0", req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_alu", {alu_a, alu_b, alu_addsub, alu_shift}, 0);
        chk("arst_rsp", {rsp0_valid, rsp0_err, rsp0_data, rsp1_valid, rsp1_err, rsp1_data}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Both requesters held valid: 0,1,0,1 with one accept every 3 cycles
        set_req(0, 1'b1, 2'b00, 8'h01, 8'h02);
        set_req(1, 1'b1, 2'b10, 8'h41, 8'h00);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_busy", i), busy, (i % 3) != 0);
            chk($sformatf("cont%0d_ready0", i), req0_ready, (i % 6) == 0);
            chk($sformatf("cont%0d_ready1", i), req1_ready, (i % 6) == 3);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
        set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
        @(negedge clk);
        chk("cont_idle", busy, 0);
        @(posedge clk); #1;

        // Requester 1 SHL with response stalled while requester 0 waits
        rsp1_ready = 1'b0;
        set_req(1, 1'b1, 2'b10, 8'h41, 8'h00);
        @(negedge clk);
        chk("stall_ready1", req1_ready, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
        set_req(0, 1'b1, 2'b00, 8'h03, 8'h04);
        @(negedge clk);
        chk("stall_exec_ready0", req0_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_rspv", k), rsp1_valid, 1);
            chk($sformatf("stall%0d_data", k), rsp1_data, 8'h82);
            chk($sformatf("stall%0d_err", k), rsp1_err, 0);
            chk($sformatf("stall%0d_ready", k), {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs_ready0", req0_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_hs_rspv1", rsp1_valid, 0);
        chk("post_hs_ready0", req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
        @(negedge clk);
        chk("post_hs_alu", {alu_a, alu_b, alu_addsub, alu_shift}, {8'h03, 8'h04, 1'b1, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("final_idle", busy, 0);
        chk("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
